// File: rtl/snn_infer_ctrl.sv
// Inference sequencer for the SNN datapath: serial image load, membrane clear, timed run, arg-max result.
// Optional build macro SNN_CTRL_SPIKE_HIST_EN exposes the live per-digit spike counters on spike_counts.
module snn_infer_ctrl #(
  parameter int INPUT_SIZE  = 784,
  parameter int PIXEL_WIDTH = 8,
  parameter int OUTPUT_SIZE = 10,
  parameter int CNT_WIDTH   = 8,
  parameter int NET_LAT     = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pix_valid,
  input  logic [PIXEL_WIDTH-1:0]            pix_data,
  output logic                              pix_ready,
  input  logic [7:0]                        num_steps_cfg,
  input  logic [7:0]                        leak_cfg,
  input  logic                              abort,
  output logic [INPUT_SIZE*PIXEL_WIDTH-1:0] pixel_input,
  output logic [7:0]                        leak_factor,
  output logic                              net_clear,
  input  logic [OUTPUT_SIZE-1:0]            digit_spikes,
  output logic                              busy,
  output logic                              result_valid,
  input  logic                              result_ready,
  output logic [3:0]                        result_digit,
  output logic                              no_spike,
  output logic [OUTPUT_SIZE*CNT_WIDTH-1:0]  spike_counts
);

  localparam int IDX_W  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int LAT_W  = (NET_LAT > 1) ? $clog2(NET_LAT) : 1;
  localparam int SCAN_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_DRAIN, S_DECIDE, S_DONE
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     pix_idx;
  logic [7:0]           num_steps;
  logic [7:0]           step_cnt;
  logic [7:0]           last_step;
  logic [LAT_W-1:0]     drain_cnt;
  logic [SCAN_W-1:0]    scan_idx;
  logic [SCAN_W-1:0]    best_idx;
  logic [CNT_WIDTH-1:0] best_val;
  logic [CNT_WIDTH-1:0] cnt [OUTPUT_SIZE];
  logic                 scan_gt;

  // A zero step count still runs the network for one timestep.
  assign last_step = (num_steps == 8'd0) ? 8'd0 : num_steps - 8'd1;
  assign scan_gt   = cnt[scan_idx] > best_val;

  // The pixel buffer is pixel_input itself; it is zeroed on entry to DRAIN so the
  // network sees no input while its pipeline empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pix_idx      <= '0;
      num_steps    <= '0;
      leak_factor  <= '0;
      step_cnt     <= '0;
      drain_cnt    <= '0;
      scan_idx     <= '0;
      best_idx     <= '0;
      best_val     <= '0;
      // NOTE: the image buffer is reset too, because pixel_input must read zero out of reset.
      pixel_input  <= '0;
      pix_ready    <= 1'b1;
      busy         <= 1'b0;
      net_clear    <= 1'b0;
      result_valid <= 1'b0;
      result_digit <= '0;
      no_spike     <= 1'b0;
    end else if (abort) begin
      state        <= S_IDLE;
      pix_idx      <= '0;
      step_cnt     <= '0;
      drain_cnt    <= '0;
      scan_idx     <= '0;
      pix_ready    <= 1'b1;
      busy         <= 1'b0;
      net_clear    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here so every register samples pre-edge values.
      net_clear <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pix_valid) begin
            pixel_input[0 +: PIXEL_WIDTH] <= pix_data;
            pix_idx     <= IDX_W'(1);
            num_steps   <= num_steps_cfg;
            leak_factor <= leak_cfg;
            busy        <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (pix_valid) begin
            pixel_input[int'(pix_idx)*PIXEL_WIDTH +: PIXEL_WIDTH] <= pix_data;
            if (pix_idx == IDX_W'(INPUT_SIZE - 1)) begin
              pix_idx   <= '0;
              pix_ready <= 1'b0;
              net_clear <= 1'b1;
              state     <= S_CLEAR;
            end else begin
              pix_idx <= pix_idx + IDX_W'(1);
            end
          end
        end
        S_CLEAR: begin
          step_cnt <= '0;
          state    <= S_RUN;
        end
        S_RUN: begin
          if (step_cnt == last_step) begin
            step_cnt    <= '0;
            drain_cnt   <= '0;
            pixel_input <= '0;
            state       <= S_DRAIN;
          end else begin
            step_cnt <= step_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == LAT_W'(NET_LAT - 1)) begin
            scan_idx <= '0;
            best_idx <= '0;
            best_val <= '0;
            state    <= S_DECIDE;
          end else begin
            drain_cnt <= drain_cnt + LAT_W'(1);
          end
        end
        S_DECIDE: begin
          // Strictly-greater replacement keeps the lowest index on ties.
          if (scan_gt) begin
            best_idx <= scan_idx;
            best_val <= cnt[scan_idx];
          end
          if (scan_idx == SCAN_W'(OUTPUT_SIZE - 1)) begin
            result_digit <= scan_gt ? scan_idx : best_idx;
            no_spike     <= (best_val == '0) && !scan_gt;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end else begin
            scan_idx <= scan_idx + SCAN_W'(1);
          end
        end
        S_DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            pix_ready    <= 1'b1;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Saturating per-digit spike counters, live during RUN and DRAIN only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) cnt[i] <= '0;
    end else if (state == S_CLEAR) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) cnt[i] <= '0;
    end else if (state == S_RUN || state == S_DRAIN) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) begin
        if (digit_spikes[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

`ifdef SNN_CTRL_SPIKE_HIST_EN
  for (genvar g = 0; g < OUTPUT_SIZE; g++) begin : g_hist
    assign spike_counts[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
  end
`else
  assign spike_counts = '0;
`endif

endmodule

// File: tb/tb_snn_infer_ctrl.sv
// Self-checking bench for snn_infer_ctrl: table of directed and random inferences against a
// behavioural model, plus hand-written abort and asynchronous-reset sequences.
module tb_snn_infer_ctrl;

  localparam int INPUT_SIZE  = 784;
  localparam int PIXEL_WIDTH = 8;
  localparam int OUTPUT_SIZE = 10;
  localparam int CNT_WIDTH   = 8;
  localparam int NET_LAT     = 2;
  localparam int IMG_W       = INPUT_SIZE * PIXEL_WIDTH;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;
  localparam int TMAX        = 400;
  localparam int NVEC        = 10;

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             pix_valid;
  logic [PIXEL_WIDTH-1:0]           pix_data;
  logic                             pix_ready;
  logic [7:0]                       num_steps_cfg;
  logic [7:0]                       leak_cfg;
  logic                             abort;
  logic [IMG_W-1:0]                 pixel_input;
  logic [7:0]                       leak_factor;
  logic                             net_clear;
  logic [OUTPUT_SIZE-1:0]           digit_spikes;
  logic                             busy;
  logic                             result_valid;
  logic                             result_ready;
  logic [3:0]                       result_digit;
  logic                             no_spike;
  logic [OUTPUT_SIZE*CNT_WIDTH-1:0] spike_counts;

  snn_infer_ctrl #(
    .INPUT_SIZE(INPUT_SIZE), .PIXEL_WIDTH(PIXEL_WIDTH), .OUTPUT_SIZE(OUTPUT_SIZE),
    .CNT_WIDTH(CNT_WIDTH), .NET_LAT(NET_LAT)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .num_steps_cfg(num_steps_cfg), .leak_cfg(leak_cfg), .abort(abort),
    .pixel_input(pixel_input), .leak_factor(leak_factor), .net_clear(net_clear),
    .digit_spikes(digit_spikes), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result_digit(result_digit), .no_spike(no_spike),
    .spike_counts(spike_counts)
  );

  always #5 clk = ~clk;

  // One inference: configuration, spike pattern (4-bit period per digit, 0 = silent) and expectations.
  typedef struct packed {
    logic [7:0]  steps;
    logic [7:0]  leak;
    logic [39:0] periods;
    logic        rand_spk;
    logic        stall;
    logic        skip8;
    logic [2:0]  hold;
    logic [3:0]  exp_digit;
    logic        exp_none;
    logic        has_exp;
  } vec_t;

  vec_t                   vecs [NVEC];
  logic [PIXEL_WIDTH-1:0] img [INPUT_SIZE];
  logic [OUTPUT_SIZE-1:0] spk [TMAX+1];
  int                     model_cnt [OUTPUT_SIZE];
  int                     n_checks = 0;
  int                     n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Compares the whole image, reporting the first differing pixel.
  task automatic check_image(input string name, input logic [IMG_W-1:0] exp_v);
    int  j = 0;
    bit  found = 0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (!found && pixel_input[i*PIXEL_WIDTH +: PIXEL_WIDTH] !== exp_v[i*PIXEL_WIDTH +: PIXEL_WIDTH]) begin
        j = i;
        found = 1;
      end
    end
    check($sformatf("%s[pix %0d]", name, j), 32'(pixel_input[j*PIXEL_WIDTH +: PIXEL_WIDTH]),
          32'(exp_v[j*PIXEL_WIDTH +: PIXEL_WIDTH]));
  endtask

  task automatic check_reset_values(input string p);
    check({p, "_pix_ready"}, 32'(pix_ready), 1);
    check({p, "_busy"}, 32'(busy), 0);
    check({p, "_net_clear"}, 32'(net_clear), 0);
    check({p, "_result_valid"}, 32'(result_valid), 0);
    check({p, "_result_digit"}, 32'(result_digit), 0);
    check({p, "_no_spike"}, 32'(no_spike), 0);
    check({p, "_leak_factor"}, 32'(leak_factor), 0);
    check({p, "_pixel_input_nonzero"}, 32'(|pixel_input), 0);
    check({p, "_spike_counts_nonzero"}, 32'(|spike_counts), 0);
  endtask

  function automatic logic [39:0] per(input int d, input int p);
    logic [39:0] r = '0;
    r[d*4 +: 4] = 4'(p);
    return r;
  endfunction

  function automatic vec_t mk(input int steps, input int leak, input logic [39:0] periods,
                              input bit rnd, input bit stall, input bit skip8, input int hold,
                              input int dig, input bit none, input bit has);
    vec_t v;
    v.steps = 8'(steps);   v.leak = 8'(leak);     v.periods = periods;
    v.rand_spk = rnd;      v.stall = stall;       v.skip8 = skip8;
    v.hold = 3'(hold);     v.exp_digit = 4'(dig); v.exp_none = none;
    v.has_exp = has;
    return v;
  endfunction

  // Serially presents pixels 0..n-1; configuration is only meaningful on the first one.
  task automatic load_image(input bit stall, input int n, input logic [7:0] steps, input logic [7:0] leak);
    for (int i = 0; i < n; i++) begin
      if (stall && i > 0) begin
        pix_valid = 1'b0;
        pix_data = 8'($urandom);
        digit_spikes = OUTPUT_SIZE'($urandom);
        @(posedge clk); #1;
      end
      pix_valid = 1'b1;
      pix_data = img[i];
      num_steps_cfg = (i == 0) ? steps : 8'($urandom);
      leak_cfg = (i == 0) ? leak : 8'($urandom);
      digit_spikes = OUTPUT_SIZE'($urandom);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
  endtask

  // Tick t counts cycles after the edge that accepted the last pixel (tick 1 is the clear cycle).
  task automatic run_vec(input int k, input vec_t v);
    string            nm = $sformatf("v%0d", k);
    int               steps_eff = (v.steps == 0) ? 1 : int'(v.steps);
    int               exp_lat = 1 + steps_eff + NET_LAT + OUTPUT_SIZE + 1;
    int               bias [OUTPUT_SIZE];
    int               best = 0;
    int               t = 1;
    int               bad = 0;
    bit               none = 1;
    logic [IMG_W-1:0] exp_img;

    for (int i = 0; i < INPUT_SIZE; i++) begin
      img[i] = PIXEL_WIDTH'($urandom);
      exp_img[i*PIXEL_WIDTH +: PIXEL_WIDTH] = img[i];
    end
    for (int d = 0; d < OUTPUT_SIZE; d++) bias[d] = $urandom_range(0, 15);
    for (int tt = 0; tt <= TMAX; tt++) begin
      for (int d = 0; d < OUTPUT_SIZE; d++) begin
        int p = int'(v.periods[d*4 +: 4]);
        if (v.rand_spk) spk[tt][d] = ($urandom_range(0, 15) < bias[d]);
        else            spk[tt][d] = (p != 0) && (tt % p == 0);
      end
      if (v.skip8 && tt == 2) spk[tt][8] = 1'b0;
    end

    // Reference: saturating counts over the RUN+DRAIN window, lowest index wins ties.
    for (int d = 0; d < OUTPUT_SIZE; d++) begin
      int c = 0;
      for (int tt = 2; tt <= 1 + steps_eff + NET_LAT; tt++)
        if (spk[tt][d]) c = (c < CNT_MAX) ? c + 1 : c;
      model_cnt[d] = c;
      if (c != 0) none = 0;
      if (c > model_cnt[best]) best = d;
    end

    check({nm, "_idle_pix_ready"}, 32'(pix_ready), 1);
    load_image(v.stall, INPUT_SIZE, v.steps, v.leak);
    check({nm, "_net_clear"}, 32'(net_clear), 1);
    check({nm, "_busy"}, 32'(busy), 1);
    check({nm, "_clear_pix_ready"}, 32'(pix_ready), 0);
    check({nm, "_leak_factor"}, 32'(leak_factor), 32'(v.leak));

    while (t < TMAX) begin
      digit_spikes = spk[t];
      if (t == 2) begin
        check({nm, "_net_clear_pulse"}, 32'(net_clear), 0);
        check_image({nm, "_run_pixel_input"}, exp_img);
      end
      if (t == 2 + steps_eff) check_image({nm, "_drain_pixel_input"}, '0);
      if (result_valid) break;
      result_ready = 1'($urandom);
      @(posedge clk); #1;
      t++;
    end
    result_ready = 1'b0;

    check({nm, "_latency"}, 32'(t), 32'(exp_lat));
    check({nm, "_result_valid"}, 32'(result_valid), 1);
    check({nm, "_result_digit"}, 32'(result_digit), 32'(best));
    check({nm, "_no_spike"}, 32'(no_spike), 32'(none));
    check({nm, "_done_pix_ready"}, 32'(pix_ready), 0);
    if (v.has_exp) begin
      check({nm, "_table_digit"}, 32'(result_digit), 32'(v.exp_digit));
      check({nm, "_table_no_spike"}, 32'(no_spike), 32'(v.exp_none));
    end
`ifdef SNN_CTRL_SPIKE_HIST_EN
    for (int d = 0; d < OUTPUT_SIZE; d++)
      check($sformatf("%s_spike_counts[%0d]", nm, d), 32'(spike_counts[d*CNT_WIDTH +: CNT_WIDTH]),
            32'(model_cnt[d]));
    if (v.has_exp && v.steps == 8'd255)
      check({nm, "_sat_count9"}, 32'(spike_counts[9*CNT_WIDTH +: CNT_WIDTH]), 32'(CNT_MAX));
`else
    check({nm, "_spike_counts_tied"}, 32'(|spike_counts), 0);
`endif

    for (int h = 0; h < int'(v.hold); h++) begin
      digit_spikes = OUTPUT_SIZE'($urandom);
      @(posedge clk); #1;
      if (!result_valid || result_digit !== 4'(best) || no_spike !== none || pix_ready || !busy) bad++;
    end
    if (v.hold != 0) check({nm, "_hold_stable_bad_cycles"}, 32'(bad), 0);

    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check({nm, "_after_result_valid"}, 32'(result_valid), 0);
    check({nm, "_after_pix_ready"}, 32'(pix_ready), 1);
    check({nm, "_after_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int seen;

    vecs[0] = mk(16, 'h5A, per(7,1) | per(3,2), 0, 0, 0, 5, 7, 0, 1);
    vecs[1] = mk(12, 'h11, per(2,1) | per(5,1) | per(0,3), 0, 0, 0, 0, 2, 0, 1);
    vecs[2] = mk(0, 'h80, '0, 0, 0, 0, 2, 0, 1, 1);
    vecs[3] = mk(5, 'h33, per(1,2) | per(6,1), 0, 1, 0, 1, 6, 0, 1);
    vecs[4] = mk(255, 'hC3, per(9,1) | per(8,1), 0, 0, 1, 0, 8, 0, 1);
    vecs[5] = mk(255, 'h07, per(9,1) | per(4,2), 0, 0, 0, 3, 9, 0, 1);
    for (int i = 6; i < NVEC; i++)
      vecs[i] = mk($urandom_range(0, 40), $urandom_range(0, 255), '0, 1, 1'($urandom), 0,
                   $urandom_range(0, 4), 0, 0, 0);

    rst = 1'b1; pix_valid = 1'b0; pix_data = '0; num_steps_cfg = '0; leak_cfg = '0;
    abort = 1'b0; digit_spikes = '0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_vec(0, vecs[0]);

    // Asynchronous reset in the middle of a load.
    for (int i = 0; i < INPUT_SIZE; i++) img[i] = PIXEL_WIDTH'($urandom_range(1, 255));
    load_image(0, 300, 8'd9, 8'h77);
    pix_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_reset_values("midload_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    pix_valid = 1'b0;
    @(posedge clk); #1;

    run_vec(1, vecs[1]);
    run_vec(2, vecs[2]);

    // Abort during RUN, then abort during LOAD with a pixel offered in the same cycle.
    for (int i = 0; i < INPUT_SIZE; i++) img[i] = PIXEL_WIDTH'($urandom);
    load_image(0, INPUT_SIZE, 8'd20, 8'h44);
    repeat (4) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_run_busy", 32'(busy), 0);
    check("abort_run_pix_ready", 32'(pix_ready), 1);
    check("abort_run_result_valid", 32'(result_valid), 0);
    check("abort_run_leak_factor", 32'(leak_factor), 32'h44);
    seen = 0;
    repeat (60) begin
      if (result_valid || busy) seen++;
      @(posedge clk); #1;
    end
    check("abort_run_no_result_cycles", 32'(seen), 0);

    load_image(0, 100, 8'd3, 8'h01);
    pix_valid = 1'b1;
    pix_data = 8'hEE;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    pix_valid = 1'b0;
    check("abort_load_busy", 32'(busy), 0);
    check("abort_load_pix_ready", 32'(pix_ready), 1);

    for (int k = 3; k < NVEC; k++) run_vec(k, vecs[k]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
